sync_debounce: RTL

SYNC_DEBOUNCE -- requirements
Module: sync_debounce

---
 rtl/sync_debounce.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a four-state debounce FSM for a slow external level.
// q changes only after DB_CYCLES+1 consecutive equal synchronized samples; rise/fall mark each accepted edge.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   IDLE_LO | q=0 accepted, watching for s2=1
//   WAIT_HI | s2=1 seen, counting stable high samples before q<=1
//   IDLE_HI | q=1 accepted, watching for s2=0
//   WAIT_LO | s2=0 seen, counting stable low samples before q<=0
module sync_debounce #(
  parameter int DB_CYCLES = 8,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic qb,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LO: begin
        cnt_d = '0;
        if (s2_q) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (!s2_q) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        cnt_d = '0;
        if (!s2_q) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (s2_q) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign q    = level_q;
  assign qb   = ~level_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == WAIT_HI) || (state_q == WAIT_LO);

endmodule
